hkspi_responder: RTL and testbench

- SPI responder (slave) at the far end of the housekeeping SPI. The host drives SCK/CSB/SDI on mprj_io[4:2]; SDO returns on mprj_io[1].
- Oversamples the SPI pins in the core clock domain and decodes command, address and data bytes.
- Issues single-cycle register write and read strobes to the housekeeping register file, e.g. address 0x13 (GPIO bit-bang control).
- Supports write-stream, read-stream and simultaneous read/write, with an optional fixed byte count and address auto-increment.

---
 rtl/hkspi_pkg.sv | 22 ++
 rtl/hkspi_sync_edge.sv | 27 ++
 rtl/hkspi_responder.sv | 191 +++++++++++++++++++
 tb/tb_hkspi_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
// Shared definitions for the housekeeping SPI responder: FSM states and
// command byte layout.
package hkspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } hk_state_e;

  localparam int CMD_WR_BIT = 7;
  localparam int CMD_RD_BIT = 6;
  localparam int CMD_N_LSB  = 3;
  localparam int CMD_N_W    = 3;

  localparam logic [7:0] CMD_WR_STREAM = 8'h80;
  localparam logic [7:0] CMD_RD_STREAM = 8'h40;
  localparam logic [7:0] CMD_RW_STREAM = 8'hC0;

endpackage

// File: rtl/hkspi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input, with a third flop
// providing single-clk rise/fall pulses of the synchronized level.
module hkspi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q    = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder (mode 0): oversamples the pads and issues
// register read/write strobes. Optional SCK-stall abort: HKSPI_TIMEOUT_EN.
module hkspi_responder
  import hkspi_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  logic sck_rise, sck_fall, csb_s, csb_fall, sdi_s;
  logic unused_sck_q, unused_csb_rise, unused_sdi_rise, unused_sdi_fall;

  hkspi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(resetn), .d(spi_sck),
    .q(unused_sck_q), .rise(sck_rise), .fall(sck_fall)
  );
  hkspi_sync_edge #(.RST_VAL(1'b1)) u_csb (
    .clk(clk), .rst_n(resetn), .d(spi_csb),
    .q(csb_s), .rise(unused_csb_rise), .fall(csb_fall)
  );
  hkspi_sync_edge #(.RST_VAL(1'b0)) u_sdi (
    .clk(clk), .rst_n(resetn), .d(spi_sdi),
    .q(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
  );

  hk_state_e           state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          rx_shift_q, rx_shift_d;
  logic [7:0]          tx_shift_q, tx_shift_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [CMD_N_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                reg_we_q, reg_we_d;
  logic                reg_re_q, reg_re_d;
  logic                inc_pend_q, inc_pend_d;
  logic [7:0]          rx_byte;
  logic                byte_done;
  logic [CMD_N_W-1:0]  cmd_n;
  logic [2:0]          unused_cmd_lsb;
  logic                tmo_hit;

  assign rx_byte        = {rx_shift_q[6:0], sdi_s};
  assign byte_done      = sck_rise && (bit_cnt_q == 3'd7);
  assign cmd_n          = cmd_q[CMD_N_LSB +: CMD_N_W];
  assign unused_cmd_lsb = cmd_q[2:0];

`ifdef HKSPI_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

  // Saturates at the limit so the abort condition holds until CSB rises.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE || sck_rise || sck_fall) tmo_cnt_d = '0;
    else if (!tmo_hit)                           tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    cmd_d       = cmd_q;
    byte_cnt_d  = byte_cnt_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    inc_pend_d  = 1'b0;

    if (state_q == IDLE) begin
      if (csb_fall) begin
        state_d    = CMD;
        bit_cnt_d  = '0;
        rx_shift_d = '0;
        tx_shift_d = '0;
        byte_cnt_d = '0;
      end
    end else if (csb_s) begin
      state_d = IDLE;
    end else begin
      if (sck_rise) begin
        bit_cnt_d  = bit_cnt_q + 3'd1;
        rx_shift_d = rx_byte;
      end
      // Hold the first bit across the byte-boundary fall.
      if (sck_fall && bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
      if (reg_re_q) tx_shift_d = 8'(reg_rdata);

      case (state_q)
        CMD: if (byte_done) begin
          cmd_d   = rx_byte;
          state_d = ((rx_byte & CMD_RW_STREAM) == 8'h00) ? IGNORE : ADDR;
        end
        ADDR: if (byte_done) begin
          reg_addr_d = ADDR_W'(rx_byte);
          reg_re_d   = cmd_q[CMD_RD_BIT];
          state_d    = DATA;
        end
        DATA: begin
          // Runs one clk after reg_we so a following read sees the new value.
          if (inc_pend_q) begin
            reg_addr_d = reg_addr_q + 1'b1;
            reg_re_d   = cmd_q[CMD_RD_BIT];
          end
          if (byte_done) begin
            if (cmd_q[CMD_WR_BIT]) begin
              reg_wdata_d = DATA_W'(rx_byte);
              reg_we_d    = 1'b1;
            end
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (cmd_n != '0 && byte_cnt_d == cmd_n) state_d = IGNORE;
            else                                    inc_pend_d = 1'b1;
          end
        end
        default: ;
      endcase

      if (tmo_hit) begin
        state_d    = IGNORE;
        reg_we_d   = 1'b0;
        reg_re_d   = 1'b0;
        inc_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      cmd_q       <= '0;
      byte_cnt_q  <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      inc_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      cmd_q       <= cmd_d;
      byte_cnt_q  <= byte_cnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      inc_pend_q  <= inc_pend_d;
    end
  end

  assign spi_sdo_oe = (state_q == DATA) && cmd_q[CMD_RD_BIT];
  assign spi_sdo    = spi_sdo_oe & tx_shift_q[7];
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_re     = reg_re_q;
  assign busy       = ~csb_s;

endmodule

// File: tb/tb_hkspi_responder.sv
// Randomized bench for hkspi_responder: a host drives SPI transactions and a
// transaction-level model predicts strobes, SDO bytes and output enable.
module tb_hkspi_responder;
  import hkspi_pkg::*;

`ifdef HKSPI_TIMEOUT_EN
  localparam int TB_TMO = 64;
`else
  localparam int TB_TMO = 4096;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       spi_sck, spi_csb, spi_sdi;
  logic       spi_sdo, spi_sdo_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  hkspi_responder #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .resetn(resetn), .spi_sck(spi_sck), .spi_csb(spi_csb),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #10 clk = ~clk;

  // Register file seen by the DUT: untouched locations read as addr+0x10.
  bit [7:0] tb_mem [256];
  bit       wr_seen [256];
  always @(posedge clk) if (reg_we) begin
    tb_mem[reg_addr]  <= reg_wdata;
    wr_seen[reg_addr] <= 1'b1;
  end
  assign reg_rdata = wr_seen[reg_addr] ? tb_mem[reg_addr] : reg_addr + 8'h10;

  logic [15:0] we_obs[$];
  logic [7:0]  re_obs[$];
  always @(negedge clk) if (resetn) begin
    if (reg_we) we_obs.push_back({reg_addr, reg_wdata});
    if (reg_re) re_obs.push_back(reg_addr);
  end

  logic [7:0] ref_mem [256];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_bit(input logic v, output logic sdo_s, output logic oe_s);
    spi_sdi = v;
    #100;
    sdo_s   = spi_sdo;
    oe_s    = spi_sdo_oe;
    spi_sck = 1'b1;
    #100;
    spi_sck = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sdo"},   spi_sdo,    0);
    check_eq({tag, "_oe"},    spi_sdo_oe, 0);
    check_eq({tag, "_addr"},  reg_addr,   0);
    check_eq({tag, "_wdata"}, reg_wdata,  0);
    check_eq({tag, "_we"},    reg_we,     0);
    check_eq({tag, "_re"},    reg_re,     0);
    check_eq({tag, "_busy"},  busy,       0);
  endtask

  // One CSB-framed transaction of nbits bits, checked against the model.
  task automatic run_txn(input string name, input logic [7:0] b[$], input int nbits);
    logic [7:0]  rxb[$], oeb[$], exp_re[$], exp_sdo[$], exp_oe[$];
    logic [15:0] exp_we[$];
    logic [7:0]  cur_rx, cur_oe, a, cmd, ak;
    logic        s, o;
    int          nfull, ndata, lim, n;
    we_obs.delete();
    re_obs.delete();
    cur_rx = '0;
    cur_oe = '0;
    spi_csb = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      send_bit(b[i/8][7 - (i % 8)], s, o);
      cur_rx = {cur_rx[6:0], s};
      cur_oe = {cur_oe[6:0], o};
      if (i % 8 == 7) begin
        rxb.push_back(cur_rx);
        oeb.push_back(cur_oe);
      end
    end
    #100;
    spi_csb = 1'b1;
    #300;

    nfull = nbits / 8;
    for (int i = 0; i < nfull; i++) exp_oe.push_back(8'h00);
    cmd = b[0];
    n   = int'(cmd[5:3]);
    if (nfull >= 2 && (cmd[7] || cmd[6])) begin
      a = b[1];
      if (cmd[6]) exp_re.push_back(a);
      ndata = nfull - 2;
      lim   = (n != 0 && ndata > n) ? n : ndata;
      for (int k = 0; k < lim; k++) begin
        ak = a + 8'(k);
        if (cmd[6]) begin
          exp_sdo.push_back(ref_mem[ak]);
          exp_oe[k+2] = 8'hFF;
        end
        if (cmd[7]) begin
          exp_we.push_back({ak, b[k+2]});
          ref_mem[ak] = b[k+2];
        end
        if (cmd[6] && !(n != 0 && k + 1 == n)) exp_re.push_back(ak + 8'd1);
      end
    end

    check_eq({name, "_nwe"}, we_obs.size(), exp_we.size());
    for (int k = 0; k < exp_we.size() && k < we_obs.size(); k++)
      check_eq($sformatf("%s_we%0d", name, k), we_obs[k], exp_we[k]);
    check_eq({name, "_nre"}, re_obs.size(), exp_re.size());
    for (int k = 0; k < exp_re.size() && k < re_obs.size(); k++)
      check_eq($sformatf("%s_re%0d", name, k), re_obs[k], exp_re[k]);
    for (int k = 0; k < exp_sdo.size(); k++)
      check_eq($sformatf("%s_sdo%0d", name, k), rxb[k+2], exp_sdo[k]);
    for (int k = 0; k < nfull; k++)
      check_eq($sformatf("%s_oe%0d", name, k), oeb[k], exp_oe[k]);
  endtask

  logic [7:0] tx_bytes[$];
  logic       s_dummy, o_dummy;

  initial begin
    spi_sck = 1'b0;
    spi_csb = 1'b1;
    spi_sdi = 1'b0;
    resetn  = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) + 8'h10;
    #43;
    check_reset_outputs("por");
    resetn = 1'b1;
    #60;

    tx_bytes = {CMD_WR_STREAM, 8'h13, 8'h36};
    run_txn("wr13", tx_bytes, 24);
    tx_bytes = {CMD_RD_STREAM, 8'h04, 8'h00, 8'h00};
    run_txn("rd04", tx_bytes, 32);
    tx_bytes = {8'h88, 8'h20, 8'hAA, 8'h55};
    run_txn("cnt1", tx_bytes, 32);
    tx_bytes = {CMD_WR_STREAM, 8'hFF, 8'h01, 8'h02};
    run_txn("wrap", tx_bytes, 32);
    tx_bytes = {CMD_WR_STREAM, 8'h13, 8'hFF};
    run_txn("abort", tx_bytes, 21);
    tx_bytes = {CMD_WR_STREAM, 8'h13, 8'h0E};
    run_txn("after_abort", tx_bytes, 24);
    tx_bytes = {CMD_RW_STREAM, 8'h13, 8'h5A, 8'hC3};
    run_txn("rw13", tx_bytes, 32);

    // Asynchronous reset in the middle of a read/write data byte.
    spi_csb = 1'b0;
    #100;
    for (int i = 0; i < 19; i++) send_bit(1'b1 ^ (i < 8 ? 1'b0 : 1'b1), s_dummy, o_dummy);
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #99;
    spi_csb = 1'b1;
    #200;
    resetn = 1'b1;
    #200;
    tx_bytes = {CMD_RW_STREAM, 8'h40, 8'h77};
    run_txn("after_rst", tx_bytes, 24);

`ifdef HKSPI_TIMEOUT_EN
    we_obs.delete();
    re_obs.delete();
    spi_csb = 1'b0;
    #100;
    tx_bytes = {CMD_RW_STREAM, 8'h50, 8'hA5, 8'h3C};
    for (int i = 0; i < 20; i++) send_bit(tx_bytes[i/8][7 - (i % 8)], s_dummy, o_dummy);
    #2000;
    for (int i = 20; i < 32; i++) send_bit(tx_bytes[i/8][7 - (i % 8)], s_dummy, o_dummy);
    check_eq("tmo_oe", spi_sdo_oe, 0);
    check_eq("tmo_busy", busy, 1);
    #100;
    spi_csb = 1'b1;
    #300;
    check_eq("tmo_nwe", we_obs.size(), 0);
    check_eq("tmo_nre", re_obs.size(), 1);
    tx_bytes = {CMD_WR_STREAM, 8'h51, 8'h99};
    run_txn("after_tmo", tx_bytes, 24);
`endif

    for (int t = 0; t < 30; t++) begin
      logic [7:0] c;
      int nd, nb;
      case ($urandom_range(0, 3))
        0:       c = CMD_WR_STREAM;
        1:       c = CMD_RD_STREAM;
        2:       c = CMD_RW_STREAM;
        default: c = 8'h00;
      endcase
      c[5:3] = ($urandom_range(0, 1) == 1) ? 3'(($urandom_range(1, 3))) : 3'd0;
      c[2:0] = 3'($urandom_range(0, 7));
      nd = $urandom_range(0, 4);
      tx_bytes = {c, 8'($urandom_range(0, 255))};
      for (int k = 0; k < nd; k++) tx_bytes.push_back(8'($urandom_range(0, 255)));
      nb = 8 * (2 + nd);
      if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 7);
      run_txn($sformatf("rnd%0d", t), tx_bytes, nb);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
